alu_iter: RTL and testbench

// - Parametrised successor to the RV32I/E math/branch ALU: same 5-bit op encoding, XLEN-wide datapath.
// - Multi-cycle FSM with explicit done; shifter is iterative, SHIFT_STEP bits/cycle, trading area for latency.
// - Sits in the execute stage; the core drives available/op/operands and waits for done.

---
 rtl/alu_iter.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_iter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// Multi-cycle RV32I-style math/branch ALU with an iterative shifter (SHIFT_STEP bits per cycle).
// Define ALU_MUL_EN to add op 01001 = MUL (shift-add, one multiplier bit per cycle, XLEN cycles).
module alu_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            available,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [XLEN-1:0] out,
    output logic            busy,
    output logic            done,
    output logic            fault
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b01101;
    localparam logic [4:0] OP_SLT  = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BNE  = 5'b10001;
    localparam logic [4:0] OP_BLT  = 5'b10100;
    localparam logic [4:0] OP_BGE  = 5'b10101;
    localparam logic [4:0] OP_BLTU = 5'b10110;
    localparam logic [4:0] OP_BGEU = 5'b10111;
`ifdef ALU_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'b01001;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fault_q, fault_d;
`ifdef ALU_MUL_EN
    logic [XLEN-1:0] acc_q, acc_d;
    logic            is_mul;
`endif

    logic            is_shift, invalid, lt_s, lt_u, eq;
    logic [CW-1:0]   step_amt;
    logic [XLEN-1:0] add_x, add_y, sum, shifted, result;
    logic            add_cin;

    always_comb begin
        is_shift = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);
        invalid  = 1'b1;
`ifdef ALU_MUL_EN
        is_mul   = 1'b0;
`endif
        case (op_q)
            OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_XOR,
            OP_OR, OP_AND, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: invalid = 1'b0;
`ifdef ALU_MUL_EN
            OP_MUL: begin
                invalid = 1'b0;
                is_mul  = 1'b1;
            end
`endif
            default: invalid = 1'b1;
        endcase
    end

    // Single adder shared by ADD/SUB and the multiplier's accumulate step.
    always_comb begin
        add_x   = a_q;
        add_y   = b_q;
        add_cin = 1'b0;
        if (op_q == OP_SUB) begin
            add_y   = ~b_q;
            add_cin = 1'b1;
        end
`ifdef ALU_MUL_EN
        if (is_mul) begin
            add_x = acc_q;
            add_y = a_q;
        end
`endif
        sum = add_x + add_y + {{(XLEN-1){1'b0}}, add_cin};
    end

    always_comb begin
        step_amt = (cnt_q < CW'(SHIFT_STEP)) ? cnt_q : CW'(SHIFT_STEP);
        case (op_q)
            OP_SLL:  shifted = a_q << step_amt;
            OP_SRL:  shifted = a_q >> step_amt;
            OP_SRA:  shifted = $unsigned($signed(a_q) >>> step_amt);
            default: shifted = a_q;
        endcase
    end

    always_comb begin
        eq     = (a_q == b_q);
        lt_s   = ($signed(a_q) < $signed(b_q));
        lt_u   = (a_q < b_q);
        result = '0;
        case (op_q)
            OP_ADD, OP_SUB: result = sum;
            OP_XOR:         result = a_q ^ b_q;
            OP_OR:          result = a_q | b_q;
            OP_AND:         result = a_q & b_q;
            OP_SLT, OP_BLT: result[0] = lt_s;
            OP_SLTU,
            OP_BLTU:        result[0] = lt_u;
            OP_BEQ:         result[0] = eq;
            OP_BNE:         result[0] = ~eq;
            OP_BGE:         result[0] = ~lt_s;
            OP_BGEU:        result[0] = ~lt_u;
            default:        result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        fault_d = fault_q;
`ifdef ALU_MUL_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (available) begin
                    op_d    = op;
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = {1'b0, in_b[SHW-1:0]};
`ifdef ALU_MUL_EN
                    acc_d   = '0;
                    if (op == OP_MUL) cnt_d = CW'(XLEN);
`endif
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!available) begin
                    state_d = S_IDLE;
                end else if (is_shift) begin
                    // A zero shift amount gives step_amt=0, so it completes on the first edge.
                    a_d   = shifted;
                    cnt_d = cnt_q - step_amt;
                    if (cnt_q == step_amt) begin
                        out_d   = shifted;
                        fault_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
`ifdef ALU_MUL_EN
                else if (is_mul) begin
                    if (b_q[0]) acc_d = sum;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        out_d   = b_q[0] ? sum : acc_q;
                        fault_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
`endif
                else begin
                    if (!invalid) out_d = result;
                    fault_d = invalid;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!available) begin
                    fault_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            fault_q <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            fault_q <= fault_d;
`ifdef ALU_MUL_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign out   = out_q;
    assign busy  = (state_q == S_EXEC);
    assign done  = (state_q == S_DONE);
    assign fault = fault_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: a reference model queues expected out/fault/busy-cycles,
// a monitor checks each completion independently of the driver.
module tb_alu_iter;
    localparam int unsigned XLEN = 32;
    localparam int unsigned STEP = 1;
    localparam int unsigned SHW  = $clog2(XLEN);

    logic            clk;
    logic            reset_n;
    logic            available;
    logic [4:0]      op;
    logic [XLEN-1:0] in_a, in_b;
    logic [XLEN-1:0] out;
    logic            busy, done, fault;

    typedef struct {
        logic [XLEN-1:0] out;
        logic            fault;
        int unsigned     cycles;
        logic [4:0]      op;
    } exp_t;

    exp_t            exp_q[$];
    logic [XLEN-1:0] last_out;
    int unsigned     n_cmp;
    int unsigned     n_bad;

    alu_iter #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .available(available), .op(op),
        .in_a(in_a), .in_b(in_b), .out(out), .busy(busy), .done(done), .fault(fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned shift_cycles(input int unsigned sh);
        return (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
    endfunction

    // Reference behaviour from plain operators; invalid ops keep the previous result.
    function automatic void model(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  input logic [XLEN-1:0] prev, output exp_t e);
        int unsigned sh;
        sh       = b[SHW-1:0];
        e.out    = '0;
        e.fault  = 1'b0;
        e.cycles = 1;
        e.op     = o;
        case (o)
            5'b00000: e.out = a + b;
            5'b01000: e.out = a - b;
            5'b00001: begin e.out = a << sh; e.cycles = shift_cycles(sh); end
            5'b00101: begin e.out = a >> sh; e.cycles = shift_cycles(sh); end
            5'b01101: begin e.out = $signed(a) >>> sh; e.cycles = shift_cycles(sh); end
            5'b00010, 5'b10100: e.out[0] = ($signed(a) < $signed(b));
            5'b00011, 5'b10110: e.out[0] = (a < b);
            5'b00100: e.out = a ^ b;
            5'b00110: e.out = a | b;
            5'b00111: e.out = a & b;
            5'b10000: e.out[0] = (a == b);
            5'b10001: e.out[0] = (a != b);
            5'b10101: e.out[0] = !($signed(a) < $signed(b));
            5'b10111: e.out[0] = !(a < b);
`ifdef ALU_MUL_EN
            5'b01001: begin e.out = a * b; e.cycles = XLEN; end
`endif
            default: begin e.out = prev; e.fault = 1'b1; end
        endcase
    endfunction

    initial begin : monitor
        logic        done_prev, busy_prev;
        int unsigned busy_cnt;
        exp_t        e;
        done_prev = 1'b0;
        busy_prev = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) busy_cnt = 0;
            if (busy) busy_cnt++;
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("out op=%b", e.op), 64'(out), 64'(e.out));
                    check($sformatf("fault op=%b", e.op), 64'(fault), 64'(e.fault));
                    check($sformatf("busy_cycles op=%b", e.op), 64'(busy_cnt), 64'(e.cycles));
                end
            end
            done_prev = done;
            busy_prev = busy;
        end
    end

    task automatic run_op(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int unsigned hold, input bit scramble);
        exp_t        e;
        int unsigned k;
        model(o, a, b, last_out, e);
        if (!e.fault) last_out = e.out;
        exp_q.push_back(e);
        @(negedge clk);
        op = o; in_a = a; in_b = b; available = 1'b1;
        @(negedge clk);
        if (scramble) begin
            op   = 5'($urandom);
            in_a = XLEN'($urandom);
            in_b = XLEN'($urandom);
        end
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            check("done_timeout", 64'(done), 64'(1));
            exp_q.delete();
        end
        repeat (hold) @(negedge clk);
        check("done_held", 64'(done), 64'(1));
        available = 1'b0;
        @(negedge clk);
        check("done_cleared", 64'(done), 64'(0));
        check("fault_cleared", 64'(fault), 64'(0));
        check("out_held", 64'(out), 64'(last_out));
    endtask

    // Request, then after 'after' EXEC cycles either drop available or pulse reset.
    task automatic interrupt_op(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input int unsigned after, input bit use_reset);
        @(negedge clk);
        op = o; in_a = a; in_b = b; available = 1'b1;
        repeat (after) @(negedge clk);
        check("busy_before_interrupt", 64'(busy), 64'(1));
        if (use_reset) begin
            #2 reset_n = 1'b0;
            #1;
            last_out = '0;
            check("rst_out", 64'(out), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            available = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
        end else begin
            available = 1'b0;
            @(negedge clk);
            check("abort_busy", 64'(busy), 64'(0));
            check("abort_done", 64'(done), 64'(0));
        end
        check("interrupt_out", 64'(out), 64'(last_out));
        repeat (2) @(negedge clk);
        check("interrupt_idle_done", 64'(done), 64'(0));
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [4:0] codes[17];
        logic [4:0] o;
        logic [XLEN-1:0] a, b;
        codes = '{5'b00000, 5'b01000, 5'b00001, 5'b00101, 5'b01101, 5'b00010, 5'b00011, 5'b00100, 5'b00110,
                  5'b00111, 5'b10000, 5'b10001, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b01001};
        n_cmp = 0;
        n_bad = 0;
        last_out  = '0;
        reset_n   = 1'b0;
        available = 1'b0;
        op = '0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        check("reset_out", 64'(out), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_fault", 64'(fault), 64'(0));
        reset_n = 1'b1;

        run_op(5'b00000, XLEN'(32'hFFFF_FFFF), XLEN'(1), 0, 0);
        run_op(5'b01000, XLEN'(5), XLEN'(7), 1, 1);
        run_op(5'b01101, XLEN'(32'h8000_0000), XLEN'(4), 0, 1);
        run_op(5'b00001, XLEN'(32'h1234_5678), XLEN'(0), 0, 0);
        run_op(5'b10100, '1, '0, 0, 0);
        run_op(5'b10110, '1, '0, 0, 0);
        run_op(5'b01010, XLEN'(3), XLEN'(4), 2, 0);
        interrupt_op(5'b00101, '1, XLEN'(20), 3, 0);
        run_op(5'b01001, '1, XLEN'(3), 0, 0);
        run_op(5'b00000, XLEN'(77), XLEN'(23), 3, 0);
        interrupt_op(5'b00001, XLEN'(1), XLEN'(31), 5, 1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) o = 5'($urandom);
            else o = codes[$urandom_range(0, 16)];
            a = XLEN'($urandom);
            b = XLEN'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            run_op(o, a, b, $urandom_range(0, 2), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
